// File: rtl/pifo_pkg.sv
// Shared PIFO definitions: dequeue-order modes, select-tree kinds and
// the strict rank comparison used by both select trees.
package pifo_pkg;

  localparam int PIFO_MIN_FIRST = 0;
  localparam int PIFO_MAX_FIRST = 1;

  localparam int SEL_BEST  = 0;
  localparam int SEL_WORST = 1;

  localparam int PIFO_RANK_MAX_W = 64;
  typedef logic [PIFO_RANK_MAX_W-1:0] rank_ext_t;

  // True when rank a must leave strictly before rank b in the given mode.
  function automatic logic better(input rank_ext_t a, input rank_ext_t b, input int mode);
    return (mode == PIFO_MAX_FIRST) ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/pifo_sel_tree.sv
// Log-depth combinational selector over DEPTH ranked slots; finds the best
// (ties to lower index) or worst (ties to higher index) valid slot.
module pifo_sel_tree
  import pifo_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int RANK_WIDTH = 16,
  parameter int MODE       = PIFO_MIN_FIRST,
  parameter int SEL        = SEL_BEST
) (
  input  logic [DEPTH*RANK_WIDTH-1:0] rank,
  input  logic [DEPTH-1:0]            valid,
  output logic [RANK_WIDTH-1:0]       win_rank,
  output logic [$clog2(DEPTH)-1:0]    win_idx,
  output logic                        any_valid
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [RANK_WIDTH-1:0] lvl_rank  [IDX_W+1][DEPTH];
  logic [IDX_W-1:0]      lvl_idx   [IDX_W+1][DEPTH];
  logic                  lvl_valid [IDX_W+1][DEPTH];
  logic                  b_better;
  logic                  take_b;

  // Level IDX_W holds the leaves; each pass pairs adjacent nodes so the left
  // child always covers the lower indices, which makes the tie rules local.
  always_comb begin
    b_better = 1'b0;
    take_b   = 1'b0;
    for (int lv = 0; lv <= IDX_W; lv++) begin
      for (int j = 0; j < DEPTH; j++) begin
        lvl_rank[lv][j]  = '0;
        lvl_idx[lv][j]   = '0;
        lvl_valid[lv][j] = 1'b0;
      end
    end
    for (int j = 0; j < DEPTH; j++) begin
      lvl_rank[IDX_W][j]  = rank[j*RANK_WIDTH +: RANK_WIDTH];
      lvl_idx[IDX_W][j]   = IDX_W'(j);
      lvl_valid[IDX_W][j] = valid[j];
    end
    for (int lv = IDX_W - 1; lv >= 0; lv--) begin
      for (int j = 0; j < DEPTH / 2; j++) begin
        b_better = better(rank_ext_t'(lvl_rank[lv+1][2*j+1]),
                          rank_ext_t'(lvl_rank[lv+1][2*j]), MODE);
        if (SEL == SEL_BEST)
          take_b = lvl_valid[lv+1][2*j+1] & (!lvl_valid[lv+1][2*j] | b_better);
        else
          take_b = lvl_valid[lv+1][2*j+1] & (!lvl_valid[lv+1][2*j] | !b_better);
        lvl_rank[lv][j]  = take_b ? lvl_rank[lv+1][2*j+1] : lvl_rank[lv+1][2*j];
        lvl_idx[lv][j]   = take_b ? lvl_idx[lv+1][2*j+1]  : lvl_idx[lv+1][2*j];
        lvl_valid[lv][j] = lvl_valid[lv+1][2*j+1] | lvl_valid[lv+1][2*j];
      end
    end
  end

  assign win_rank  = lvl_rank[0][0];
  assign win_idx   = lvl_idx[0][0];
  assign any_valid = lvl_valid[0][0];

endmodule

// File: rtl/pifo_sched_reg.sv
// Compacted push-in/first-out register: arrival-ordered slots, head chosen by
// rank (min- or max-first), eviction of the worst entry or the newcomer when full.
module pifo_sched_reg
  import pifo_pkg::*;
#(
  parameter int L2_DEPTH   = 3,
  parameter int RANK_WIDTH = 16,
  parameter int META_WIDTH = 32,
  parameter int MODE       = PIFO_MIN_FIRST,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RANK_WIDTH-1:0] in_rank,
  input  logic [META_WIDTH-1:0] in_meta,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RANK_WIDTH-1:0] out_rank,
  output logic [META_WIDTH-1:0] out_meta,
  output logic                  drop_valid,
  output logic [RANK_WIDTH-1:0] drop_rank,
  output logic [META_WIDTH-1:0] drop_meta,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [L2_DEPTH:0]     num_entries,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << L2_DEPTH;
  localparam int IDX_W = L2_DEPTH;
  localparam logic [L2_DEPTH:0] ONE_ENTRY  = (L2_DEPTH+1)'(1);
  localparam logic [L2_DEPTH:0] FULL_COUNT = (L2_DEPTH+1)'(DEPTH);

  logic [RANK_WIDTH-1:0]       rank_q [DEPTH];
  logic [RANK_WIDTH-1:0]       rank_d [DEPTH];
  logic [META_WIDTH-1:0]       meta_q [DEPTH];
  logic [META_WIDTH-1:0]       meta_d [DEPTH];
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [L2_DEPTH:0]           count_d;
  logic [IDX_W-1:0]            head_idx;
  logic [DEPTH*RANK_WIDTH-1:0] rank_flat;

  logic [RANK_WIDTH-1:0] best_rank, worst_rank;
  logic [IDX_W-1:0]      best_idx, worst_idx;
  logic                  best_any, worst_any;

  logic                  ins, deq;
  logic                  remove, append;
  logic [IDX_W-1:0]      rem_idx, app_idx;
  logic                  drop_d;
  logic [RANK_WIDTH-1:0] drop_rank_d;
  logic [META_WIDTH-1:0] drop_meta_d;

  assign in_ready = !flush;
  assign ins      = in_valid & in_ready;
  assign deq      = out_valid & out_ready;

  always_comb begin
    rank_flat = '0;
    for (int i = 0; i < DEPTH; i++)
      rank_flat[i*RANK_WIDTH +: RANK_WIDTH] = rank_q[i];
  end

  pifo_sel_tree #(
    .DEPTH(DEPTH), .RANK_WIDTH(RANK_WIDTH), .MODE(MODE), .SEL(SEL_BEST)
  ) u_best (
    .rank(rank_flat), .valid(valid_q),
    .win_rank(best_rank), .win_idx(best_idx), .any_valid(best_any)
  );

  pifo_sel_tree #(
    .DEPTH(DEPTH), .RANK_WIDTH(RANK_WIDTH), .MODE(MODE), .SEL(SEL_WORST)
  ) u_worst (
    .rank(rank_flat), .valid(valid_q),
    .win_rank(worst_rank), .win_idx(worst_idx), .any_valid(worst_any)
  );

  // Every array change is at most one removal (shift down) then one tail append.
  always_comb begin
    rank_d      = rank_q;
    meta_d      = meta_q;
    valid_d     = valid_q;
    count_d     = num_entries;
    remove      = 1'b0;
    rem_idx     = '0;
    append      = 1'b0;
    app_idx     = '0;
    drop_d      = 1'b0;
    drop_rank_d = in_rank;
    drop_meta_d = in_meta;

    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end else if (deq) begin
      remove  = 1'b1;
      rem_idx = head_idx;
      if (ins) begin
        append  = 1'b1;
        app_idx = IDX_W'(num_entries - ONE_ENTRY);
      end else begin
        count_d = num_entries - ONE_ENTRY;
      end
    end else if (ins) begin
      if (!full) begin
        append  = 1'b1;
        app_idx = IDX_W'(num_entries);
        count_d = num_entries + ONE_ENTRY;
      end else if (worst_any && better(rank_ext_t'(in_rank), rank_ext_t'(worst_rank), MODE)) begin
        remove      = 1'b1;
        rem_idx     = worst_idx;
        append      = 1'b1;
        app_idx     = IDX_W'(DEPTH - 1);
        drop_d      = 1'b1;
        drop_rank_d = worst_rank;
        drop_meta_d = meta_q[worst_idx];
      end else begin
        drop_d = 1'b1;
      end
    end

    if (remove) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= rem_idx) begin
          rank_d[i]  = rank_q[i+1];
          meta_d[i]  = meta_q[i+1];
          valid_d[i] = valid_q[i+1];
        end
      end
      valid_d[DEPTH-1] = 1'b0;
    end

    if (append) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (IDX_W'(i) == app_idx) begin
          rank_d[i]  = in_rank;
          meta_d[i]  = in_meta;
          valid_d[i] = 1'b1;
        end
      end
    end
  end

  // The head is only advertised after a quiet cycle, so head_idx always
  // names the entry currently shown on out_*.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      num_entries <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      out_valid   <= 1'b0;
      out_rank    <= '0;
      out_meta    <= '0;
      head_idx    <= '0;
      drop_valid  <= 1'b0;
      drop_rank   <= '0;
      drop_meta   <= '0;
      drop_cnt    <= '0;
    end else begin
      valid_q     <= valid_d;
      num_entries <= count_d;
      empty       <= (count_d == '0);
      full        <= (count_d == FULL_COUNT);
      out_valid   <= best_any & !(ins | deq | flush);
      out_rank    <= best_rank;
      out_meta    <= meta_q[best_idx];
      head_idx    <= best_idx;
      drop_valid  <= drop_d;
      drop_rank   <= drop_rank_d;
      drop_meta   <= drop_meta_d;
      if (drop_d && (drop_cnt != '1))
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    rank_q <= rank_d;
    meta_q <= meta_d;
  end

endmodule

// File: tb/tb_pifo_sched_reg.sv
// Drives a min-first and a max-first instance with the same directed vectors and
// checks both against a queue-level model every cycle plus hand-computed values.
module tb_pifo_sched_reg;

  localparam int RW = 16;
  localparam int MW = 32;
  localparam int CW = 32;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [RW-1:0] in_rank = '0;
  logic [MW-1:0] in_meta = '0;

  logic [1:0]    ir_d, ov_d, dv_d, em_d, fu_d;
  logic [RW-1:0] or_d [2];
  logic [MW-1:0] om_d [2];
  logic [RW-1:0] dr_d [2];
  logic [MW-1:0] dm_d [2];
  logic [CW-1:0] dc_d [2];
  logic [3:0]    ne_d [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pifo_sched_reg #(.L2_DEPTH(3), .RANK_WIDTH(RW), .META_WIDTH(MW), .MODE(0), .CNT_WIDTH(CW)) dut_min (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_d[0]), .in_rank(in_rank), .in_meta(in_meta),
    .out_valid(ov_d[0]), .out_ready(out_ready), .out_rank(or_d[0]), .out_meta(om_d[0]),
    .drop_valid(dv_d[0]), .drop_rank(dr_d[0]), .drop_meta(dm_d[0]), .drop_cnt(dc_d[0]),
    .num_entries(ne_d[0]), .empty(em_d[0]), .full(fu_d[0])
  );

  pifo_sched_reg #(.L2_DEPTH(3), .RANK_WIDTH(RW), .META_WIDTH(MW), .MODE(1), .CNT_WIDTH(CW)) dut_max (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_d[1]), .in_rank(in_rank), .in_meta(in_meta),
    .out_valid(ov_d[1]), .out_ready(out_ready), .out_rank(or_d[1]), .out_meta(om_d[1]),
    .drop_valid(dv_d[1]), .drop_rank(dr_d[1]), .drop_meta(dm_d[1]), .drop_cnt(dc_d[1]),
    .num_entries(ne_d[1]), .empty(em_d[1]), .full(fu_d[1])
  );

  // Reference model: per instance, a list of items in arrival order.
  int            m_cnt [2] = '{0, 0};
  logic [RW-1:0] m_rk  [2][D];
  logic [MW-1:0] m_mt  [2][D];
  logic          m_ov  [2] = '{1'b0, 1'b0};
  logic [RW-1:0] m_or  [2];
  logic [MW-1:0] m_om  [2];
  logic          m_dv  [2] = '{1'b0, 1'b0};
  logic [RW-1:0] m_dr  [2];
  logic [MW-1:0] m_dm  [2];
  logic [CW-1:0] m_dc  [2] = '{'0, '0};

  function automatic bit m_better(input logic [RW-1:0] a, input logic [RW-1:0] b, input int mode);
    return (mode == 1) ? (a > b) : (a < b);
  endfunction

  task automatic m_remove(input int m, input int idx);
    for (int i = idx; i < m_cnt[m] - 1; i++) begin
      m_rk[m][i] = m_rk[m][i+1];
      m_mt[m][i] = m_mt[m][i+1];
    end
    m_cnt[m] = m_cnt[m] - 1;
  endtask

  task automatic m_append(input int m);
    m_rk[m][m_cnt[m]] = in_rank;
    m_mt[m][m_cnt[m]] = in_meta;
    m_cnt[m] = m_cnt[m] + 1;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      for (int m = 0; m < 2; m++) begin
        if (rst) begin
          m_cnt[m] = 0; m_ov[m] = 1'b0; m_dv[m] = 1'b0; m_dc[m] = '0;
        end else begin
          bit ins, deq;
          int b, w;
          ins = in_valid && !flush;
          deq = m_ov[m] && out_ready;
          b = 0;
          w = 0;
          for (int i = 1; i < m_cnt[m]; i++) begin
            if (m_better(m_rk[m][i], m_rk[m][b], m)) b = i;
            if (!m_better(m_rk[m][i], m_rk[m][w], m)) w = i;
          end
          m_or[m] = m_rk[m][b];
          m_om[m] = m_mt[m][b];
          m_ov[m] = (m_cnt[m] > 0) && !(ins || deq || flush);
          m_dv[m] = 1'b0;
          if (flush) begin
            m_cnt[m] = 0;
          end else if (deq) begin
            m_remove(m, b);
            if (ins) m_append(m);
          end else if (ins) begin
            if (m_cnt[m] < D) begin
              m_append(m);
            end else if (m_better(in_rank, m_rk[m][w], m)) begin
              m_dv[m] = 1'b1; m_dr[m] = m_rk[m][w]; m_dm[m] = m_mt[m][w];
              m_remove(m, w);
              m_append(m);
            end else begin
              m_dv[m] = 1'b1; m_dr[m] = in_rank; m_dm[m] = in_meta;
            end
          end
          if (m_dv[m] && (m_dc[m] != '1)) m_dc[m] = m_dc[m] + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s[%0d]: got %0h, expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int m = 0; m < 2; m++) begin
          checkOutput("in_ready", m, 64'(ir_d[m]), 64'(!flush));
          checkOutput("out_valid", m, 64'(ov_d[m]), 64'(m_ov[m]));
          if (m_ov[m]) begin
            checkOutput("out_rank", m, 64'(or_d[m]), 64'(m_or[m]));
            checkOutput("out_meta", m, 64'(om_d[m]), 64'(m_om[m]));
          end
          checkOutput("num_entries", m, 64'(ne_d[m]), 64'(m_cnt[m]));
          checkOutput("empty", m, 64'(em_d[m]), 64'(m_cnt[m] == 0));
          checkOutput("full", m, 64'(fu_d[m]), 64'(m_cnt[m] == D));
          checkOutput("drop_valid", m, 64'(dv_d[m]), 64'(m_dv[m]));
          if (m_dv[m]) begin
            checkOutput("drop_rank", m, 64'(dr_d[m]), 64'(m_dr[m]));
            checkOutput("drop_meta", m, 64'(dm_d[m]), 64'(m_dm[m]));
          end
          checkOutput("drop_cnt", m, 64'(dc_d[m]), 64'(m_dc[m]));
        end
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Holds the given inputs for exactly one active edge.
  task automatic applyStimulus(input logic iv, input logic [RW-1:0] r, input logic [MW-1:0] mt,
                               input logic ordy, input logic fl);
    in_valid  = iv;
    in_rank   = r;
    in_meta   = mt;
    out_ready = ordy;
    flush     = fl;
    stepCycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic waitHead();
    int n;
    n = 0;
    while (!(ov_d[0] && ov_d[1]) && n < 8) begin
      stepCycle();
      n++;
    end
    checkOutput("head_timeout", 0, 64'(ov_d[0] && ov_d[1]), 64'(1));
  endtask

  task automatic dequeueCheck(input int r0, input int mt0, input int r1, input int mt1);
    waitHead();
    checkOutput("deq_rank", 0, 64'(or_d[0]), 64'(r0));
    checkOutput("deq_meta", 0, 64'(om_d[0]), 64'(mt0));
    checkOutput("deq_rank", 1, 64'(or_d[1]), 64'(r1));
    checkOutput("deq_meta", 1, 64'(om_d[1]), 64'(mt1));
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      checkOutput("reset_empty", m, 64'(em_d[m]), 64'(1));
      checkOutput("reset_num", m, 64'(ne_d[m]), 64'(0));
      checkOutput("reset_out_valid", m, 64'(ov_d[m]), 64'(0));
    end

    // Ordering and FIFO tie-break in both modes.
    applyStimulus(1'b1, 16'd5, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd2, 32'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd9, 32'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd2, 32'd3, 1'b0, 1'b0);
    dequeueCheck(2, 1, 9, 2);
    dequeueCheck(2, 3, 5, 0);
    dequeueCheck(5, 0, 2, 1);
    dequeueCheck(9, 2, 2, 3);
    for (int m = 0; m < 2; m++) checkOutput("empty_after_drain", m, 64'(em_d[m]), 64'(1));

    // Full: eviction of the worst entry versus dropping the newcomer.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, RW'(10 + i), MW'(100 + i), 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) checkOutput("full_after_fill", m, 64'(fu_d[m]), 64'(1));
    applyStimulus(1'b1, 16'd3, 32'd200, 1'b0, 1'b0);
    checkOutput("evict_valid", 0, 64'(dv_d[0]), 64'(1));
    checkOutput("evict_rank", 0, 64'(dr_d[0]), 64'(17));
    checkOutput("evict_meta", 0, 64'(dm_d[0]), 64'(107));
    checkOutput("reject_valid", 1, 64'(dv_d[1]), 64'(1));
    checkOutput("reject_rank", 1, 64'(dr_d[1]), 64'(3));
    checkOutput("reject_meta", 1, 64'(dm_d[1]), 64'(200));
    for (int m = 0; m < 2; m++) checkOutput("full_after_drop", m, 64'(fu_d[m]), 64'(1));
    applyStimulus(1'b1, 16'd17, 32'd201, 1'b0, 1'b0);
    checkOutput("reject_rank", 0, 64'(dr_d[0]), 64'(17));
    checkOutput("reject_meta", 0, 64'(dm_d[0]), 64'(201));
    checkOutput("evict_rank", 1, 64'(dr_d[1]), 64'(10));
    checkOutput("evict_meta", 1, 64'(dm_d[1]), 64'(100));
    stepCycle();
    for (int m = 0; m < 2; m++) checkOutput("drop_cnt_two", m, 64'(dc_d[m]), 64'(2));

    // Simultaneous insert and dequeue while full.
    waitHead();
    checkOutput("head_rank", 0, 64'(or_d[0]), 64'(3));
    checkOutput("head_meta", 0, 64'(om_d[0]), 64'(200));
    checkOutput("head_rank", 1, 64'(or_d[1]), 64'(17));
    checkOutput("head_meta", 1, 64'(om_d[1]), 64'(107));
    applyStimulus(1'b1, 16'd1, 32'd300, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checkOutput("swap_num", m, 64'(ne_d[m]), 64'(8));
      checkOutput("swap_no_drop", m, 64'(dv_d[m]), 64'(0));
      checkOutput("swap_gap", m, 64'(ov_d[m]), 64'(0));
    end
    stepCycle();
    for (int m = 0; m < 2; m++) checkOutput("swap_recover", m, 64'(ov_d[m]), 64'(1));
    checkOutput("swap_head_rank", 0, 64'(or_d[0]), 64'(1));
    checkOutput("swap_head_meta", 0, 64'(om_d[0]), 64'(300));
    checkOutput("swap_head_rank", 1, 64'(or_d[1]), 64'(17));
    checkOutput("swap_head_meta", 1, 64'(om_d[1]), 64'(201));

    // Flush wins over a concurrent insert and dequeue.
    applyStimulus(1'b1, 16'd5, 32'd0, 1'b1, 1'b1);
    for (int m = 0; m < 2; m++) begin
      checkOutput("flush_num", m, 64'(ne_d[m]), 64'(0));
      checkOutput("flush_empty", m, 64'(em_d[m]), 64'(1));
      checkOutput("flush_no_drop", m, 64'(dv_d[m]), 64'(0));
    end
    stepCycle();
    for (int m = 0; m < 2; m++) begin
      checkOutput("flush_out_valid", m, 64'(ov_d[m]), 64'(0));
      checkOutput("flush_drop_cnt", m, 64'(dc_d[m]), 64'(2));
    end

    // Asynchronous reset between edges, then a fresh insert.
    applyStimulus(1'b1, 16'd4, 32'd40, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd3, 32'd41, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd2, 32'd42, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd1, 32'd43, 1'b0, 1'b0);
    waitHead();
    #1;
    rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      checkOutput("arst_num", m, 64'(ne_d[m]), 64'(0));
      checkOutput("arst_empty", m, 64'(em_d[m]), 64'(1));
      checkOutput("arst_full", m, 64'(fu_d[m]), 64'(0));
      checkOutput("arst_out_valid", m, 64'(ov_d[m]), 64'(0));
      checkOutput("arst_out_rank", m, 64'(or_d[m]), 64'(0));
      checkOutput("arst_out_meta", m, 64'(om_d[m]), 64'(0));
      checkOutput("arst_drop_valid", m, 64'(dv_d[m]), 64'(0));
      checkOutput("arst_drop_rank", m, 64'(dr_d[m]), 64'(0));
      checkOutput("arst_drop_meta", m, 64'(dm_d[m]), 64'(0));
      checkOutput("arst_drop_cnt", m, 64'(dc_d[m]), 64'(0));
    end
    #1;
    rst = 1'b0;
    stepCycle();
    applyStimulus(1'b1, 16'd7, 32'd9, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) checkOutput("post_rst_gap", m, 64'(ov_d[m]), 64'(0));
    stepCycle();
    for (int m = 0; m < 2; m++) begin
      checkOutput("post_rst_valid", m, 64'(ov_d[m]), 64'(1));
      checkOutput("post_rst_rank", m, 64'(or_d[m]), 64'(7));
      checkOutput("post_rst_meta", m, 64'(om_d[m]), 64'(9));
      checkOutput("post_rst_num", m, 64'(ne_d[m]), 64'(1));
    end
    stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pifo_sched_reg.md
# pifo_sched_reg

Parametrised successor to the single-mode PIFO register. It is a DEPTH-entry push-in/first-out register with selectable dequeue order (min-first or max-first) and strict FIFO tie-breaking among equal ranks. It also supports eviction with drop reporting when full, a synchronous flush, a valid/ready dequeue handshake and a saturating drop counter. It sits between the rank-computation stage and the egress scheduler, one instance per output port.

## Interface
- L2_DEPTH, 3: log2 of entry count; DEPTH = 2**L2_DEPTH, L2_DEPTH ≥ 1
- RANK_WIDTH, 16: rank width, unsigned
- META_WIDTH, 32: opaque metadata width
- MODE, 0: 0 = smallest rank dequeued first; 1 = largest rank dequeued first
- CNT_WIDTH, 32: drop counter width
- clk  in  1  sole clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  synchronous clear of all entries
- in_valid  in  1  insert request
- in_ready  out  1  equals !flush (combinational)
- in_rank  in  RANK_WIDTH  rank of inserted item
- in_meta  in  META_WIDTH  metadata of inserted item
- out_valid  out  1  head item valid (registered)
- out_ready  in  1  consumer takes head when out_valid & out_ready
- out_rank  out  RANK_WIDTH  head rank (registered)
- out_meta  out  META_WIDTH  head metadata (registered)
- drop_valid  out  1  one-cycle pulse: an item was discarded
- drop_rank  out  RANK_WIDTH  rank of discarded item
- drop_meta  out  META_WIDTH  metadata of discarded item
- drop_cnt  out  CNT_WIDTH  total drops, saturating
- num_entries  out  L2_DEPTH+1  occupancy
- empty  out  1  num_entries == 0
- full  out  1  num_entries == DEPTH

## Operation
- Storage: arrays rank/meta/valid[DEPTH]. The array is always compacted: entries occupy indices 0..num_entries-1. Index order equals arrival order (0 = oldest).
- Best entry: min rank (MODE 0) or max rank (MODE 1). On ties, the lowest index (oldest) wins.
- Worst entry: the opposite extreme. On ties, the highest index (newest) is chosen.
- Events in a cycle: ins = in_valid & in_ready; deq = out_valid & out_ready; flush.
- Priority:
  - flush: clear all valid bits and set num_entries = 0. Ins and deq in the same cycle are ignored; no drop is reported.
  - deq & !ins: remove the best entry (the index latched with out_*). Shift higher entries down by one; num_entries − 1.
  - deq & ins: remove the best entry, shift down, append the new item at the tail; num_entries unchanged; no drop.
  - ins & !full: append at index num_entries; num_entries + 1.
  - ins & full: compare in_rank with the worst rank.
    - If the new item is strictly better than the worst entry: evict the worst entry (drop_* = evicted item), shift down, append the new item.
    - Otherwise (worse or equal): drop the incoming item (drop_* = in_*). The array is unchanged.
- drop_cnt increments on every drop_valid and holds at all-ones.
- empty, full and num_entries are registered and updated on the same edge as the array.

## Timing
- Reset values (asynchronous):
  - num_entries = 0, empty = 1, full = 0
  - out_valid = 0, out_rank = 0, out_meta = 0
  - drop_valid = 0, drop_rank = 0, drop_meta = 0, drop_cnt = 0
  - all valid bits = 0
- out_* register load, every cycle: out_* <= best of the current array. out_valid <= tree_valid & !(ins | deq | flush).
- Latency for any array change in cycle N: out_valid = 0 in cycle N+1; the new head is valid in cycle N+2. Maximum dequeue rate is one item per 2 cycles.
- An insert into an empty block in cycle N gives out_valid in cycle N+2.
- drop_valid/drop_* are registered and asserted in cycle N+1 for a drop decided in cycle N.
- Reset asserted mid-operation clears state immediately. Contents are lost and no drop is reported.

## Structure
- Shared package pifo_pkg:
  - mode constants PIFO_MIN_FIRST = 0, PIFO_MAX_FIRST = 1
  - a function better(a, b, mode) returning the strict comparison used by both trees
- One sub-module, pifo_sel_tree: a log-depth combinational select tree with parameters DEPTH, RANK_WIDTH and SEL_BEST/SEL_WORST.
  - Inputs: rank/valid vectors.
  - Outputs: winning rank, index and any_valid.
  - Tie rule: lower index wins for best, higher index wins for worst.
  - The top level instantiates the tree twice.

## Test plan
- Ordering, MODE 0, DEPTH 8: insert ranks 5, 2, 9, 2 (meta 0..3), then dequeue all → out_rank 2 (meta 1), 2 (meta 3), 5, 9; empty = 1 after the last dequeue.
- MODE 1, same stimulus → order 9, 5, 2 (meta 1), 2 (meta 3).
- Full eviction, MODE 0: fill 8 entries with ranks 10..17, then insert rank 3 → drop_valid for rank 17, full stays 1, next head rank 3. Then insert rank 17 → incoming dropped, drop_cnt = 2.
- Simultaneous insert and dequeue while full, rank 1 → head removed, rank 1 appended, num_entries = 8, no drop_valid; out_valid is low for exactly one cycle.
- Flush asserted with in_valid and out_ready high → num_entries = 0, empty = 1, no drop, out_valid = 0 two cycles later.
- Asynchronous rst pulse between clock edges with 4 entries → all outputs at reset values before the next edge; a subsequent insert behaves as in an empty block.
